// File: rtl/inst_queue_id_if.sv
// rtl/inst_queue_id_if.sv - fetch/decode handshake bundle for the instruction queue
//
// Purpose: groups the fetch-side push channel, the decode-side head channel,
//          the flush request and the occupancy count into one bundle.
// Ports (signals):
//    flush         discard all queued entries
//    in_valid      fetch presents {in_pc, in_inst}
//    in_ready      queue can accept a push
//    in_pc         PC of the fetched instruction
//    in_inst       fetched instruction word
//    out_valid     head entry valid
//    out_ready     decode accepts the head
//    out_pc        head PC
//    out_inst      head instruction
//    out_imm16     head inst[15:0]
//    out_imm_sext  1 = sign-extend out_imm16, 0 = zero-extend
//    count         occupancy, 0..DEPTH
// Modports: master = fetch/decode side (testbench), slave = the queue.

interface inst_queue_id_if #(
   parameter int DEPTH = 4
);
   localparam int PTR_W = $clog2(DEPTH);

   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_pc;
   logic [31:0]      in_inst;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_pc;
   logic [31:0]      out_inst;
   logic [15:0]      out_imm16;
   logic             out_imm_sext;
   logic [PTR_W:0]   count;

   modport master (
      output flush, in_valid, in_pc, in_inst, out_ready,
      input  in_ready, out_valid, out_pc, out_inst, out_imm16, out_imm_sext, count
   );

   modport slave (
      input  flush, in_valid, in_pc, in_inst, out_ready,
      output in_ready, out_valid, out_pc, out_inst, out_imm16, out_imm_sext, count
   );
endinterface

// File: rtl/inst_queue_id.sv
// rtl/inst_queue_id.sv - instruction queue between fetch and decode
//
// Purpose: buffers fetched {pc, inst} pairs in a DEPTH-entry circular queue
//          and presents the head to decode with the 16-bit immediate and its
//          extension select already decoded. Supports flush on redirect.
// Ports:
//    clk   rising-edge clock
//    rst   synchronous reset, active-high
//    q     inst_queue_id_if.slave: push channel, head channel, flush, count

module inst_queue_id #(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   inst_queue_id_if.slave   q
);
   localparam int             PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0] ONE_CNT  = (PTR_W + 1)'(1);

   logic [31:0]      pc_mem   [DEPTH];
   logic [31:0]      inst_mem [DEPTH];
   logic             sext_mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count_r;

   logic             in_ready;
   logic             out_valid;
   logic             push;
   logic             pop;
   logic             in_sext;

   // Ready is derived from the registered count only, so a pop in the same
   // cycle never opens a slot for a push while full.
   assign in_ready  = (count_r != FULL_CNT);
   assign out_valid = (count_r != '0);
   assign push      = q.in_valid & in_ready;
   assign pop       = out_valid & q.out_ready;

   // ANDI/ORI/XORI/LUI (opcodes 0011xx) use a zero-extended immediate;
   // every other opcode sign-extends.
   assign in_sext   = (q.in_inst[31:28] != 4'b0011);

   // Storage carries no reset: stale entries are masked by out_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= q.in_pc;
         inst_mem[wr_ptr] <= q.in_inst;
         sext_mem[wr_ptr] <= in_sext;
      end
   end

   // Flush and reset share one effect and override any push/pop that cycle.
   always_ff @(posedge clk) begin
      if (rst || q.flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_r <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + ONE_CNT;
            2'b01:   count_r <= count_r - ONE_CNT;
            default: count_r <= count_r;
         endcase
      end
   end

   // Head outputs read straight from the rd_ptr entry; forced to a NOP
   // (all zero) whenever the queue is empty.
   always_comb begin
      q.out_pc       = '0;
      q.out_inst     = '0;
      q.out_imm16    = '0;
      q.out_imm_sext = 1'b0;
      if (out_valid) begin
         q.out_pc       = pc_mem[rd_ptr];
         q.out_inst     = inst_mem[rd_ptr];
         q.out_imm16    = inst_mem[rd_ptr][15:0];
         q.out_imm_sext = sext_mem[rd_ptr];
      end
   end

   assign q.in_ready  = in_ready;
   assign q.out_valid = out_valid;
   assign q.count     = count_r;

endmodule

// File: tb/tb_inst_queue_id.sv
// tb/tb_inst_queue_id.sv - directed self-checking bench for inst_queue_id
//
// Purpose: drives directed push/pop/flush/reset sequences and compares every
//          observed output with hand-computed values.
// Ports: none (top-level bench).

module tb_inst_queue_id;
   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   inst_queue_id_if #(.DEPTH(4)) bus ();

   inst_queue_id #(.DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .q   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_pc     = '0;
      bus.in_inst   = '0;
      bus.out_ready = 1'b0;
   endtask

   task automatic push_one(input logic [31:0] pc, input logic [31:0] inst);
      bus.in_valid = 1'b1;
      bus.in_pc    = pc;
      bus.in_inst  = inst;
      tick();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // reset state
      check("rst_count",     64'(bus.count), 64'd0);
      check("rst_in_ready",  64'(bus.in_ready), 64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_inst",  64'(bus.out_inst), 64'd0);
      check("rst_out_pc",    64'(bus.out_pc), 64'd0);

      // 1: LUI push, zero-extended immediate
      push_one(32'hBFC0_0000, 32'h3C08_BFC0);
      check("t1_out_valid", 64'(bus.out_valid), 64'd1);
      check("t1_out_pc",    64'(bus.out_pc), 64'hBFC0_0000);
      check("t1_imm16",     64'(bus.out_imm16), 64'hBFC0);
      check("t1_sext",      64'(bus.out_imm_sext), 64'd0);
      check("t1_count",     64'(bus.count), 64'd1);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("t1_drain", 64'(bus.count), 64'd0);

      // 2: ADDIU with decode ready, sign-extended immediate
      bus.out_ready = 1'b1;
      push_one(32'h0000_1000, 32'h2508_FFFC);
      check("t2_out_valid", 64'(bus.out_valid), 64'd1);
      check("t2_sext",      64'(bus.out_imm_sext), 64'd1);
      check("t2_imm16",     64'(bus.out_imm16), 64'hFFFC);
      check("t2_count_n1",  64'(bus.count), 64'd1);
      tick();
      check("t2_count_n2",  64'(bus.count), 64'd0);
      check("t2_valid_n2",  64'(bus.out_valid), 64'd0);
      bus.out_ready = 1'b0;

      // 3: fill while stalled, fifth push ignored, drain in order
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t3_ready_before_%0d", i), 64'(bus.in_ready), (i < 4) ? 64'd1 : 64'd0);
         push_one(32'h0000_0100 + 32'(4 * i), 32'h3400_0000 | 32'(i));
         check($sformatf("t3_count_%0d", i), 64'(bus.count), (i < 4) ? 64'(i + 1) : 64'd4);
         check($sformatf("t3_head_%0d", i), 64'(bus.out_pc), 64'h100);
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t3_pop_pc_%0d", i), 64'(bus.out_pc), 64'h100 + 64'(4 * i));
         check($sformatf("t3_pop_inst_%0d", i), 64'(bus.out_inst), 64'h3400_0000 | 64'(i));
         tick();
      end
      bus.out_ready = 1'b0;
      check("t3_empty_count", 64'(bus.count), 64'd0);
      check("t3_empty_valid", 64'(bus.out_valid), 64'd0);
      check("t3_empty_pc",    64'(bus.out_pc), 64'd0);

      // 4: steady push+pop at count=1 over 10 cycles (pointers wrap)
      push_one(32'h0000_0200, 32'h2400_0200);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         check($sformatf("t4_valid_%0d", k), 64'(bus.out_valid), 64'd1);
         check($sformatf("t4_head_%0d", k), 64'(bus.out_pc), 64'h200 + 64'(4 * k));
         bus.in_valid = 1'b1;
         bus.in_pc    = 32'h0000_0200 + 32'(4 * (k + 1));
         bus.in_inst  = 32'h2400_0200 + 32'(4 * (k + 1));
         tick();
         check($sformatf("t4_count_%0d", k), 64'(bus.count), 64'd1);
      end
      bus.in_valid = 1'b0;
      check("t4_last_head", 64'(bus.out_pc), 64'h228);
      check("t4_last_inst", 64'(bus.out_inst), 64'h2400_0228);
      tick();
      bus.out_ready = 1'b0;
      check("t4_drained", 64'(bus.count), 64'd0);

      // 5: flush at count=3 with concurrent push and pop
      push_one(32'h0000_0300, 32'h2400_0001);
      push_one(32'h0000_0304, 32'h2400_0002);
      push_one(32'h0000_0308, 32'h2400_0003);
      check("t5_count_pre", 64'(bus.count), 64'd3);
      bus.flush     = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_pc     = 32'h0000_03FC;
      bus.in_inst   = 32'h2400_00FF;
      bus.out_ready = 1'b1;
      tick();
      idle();
      check("t5_count",     64'(bus.count), 64'd0);
      check("t5_out_valid", 64'(bus.out_valid), 64'd0);
      check("t5_out_inst",  64'(bus.out_inst), 64'd0);
      check("t5_in_ready",  64'(bus.in_ready), 64'd1);
      push_one(32'h0000_0400, 32'h3800_0001);
      check("t5_new_pc",    64'(bus.out_pc), 64'h400);
      check("t5_new_sext",  64'(bus.out_imm_sext), 64'd0);
      check("t5_new_count", 64'(bus.count), 64'd1);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("t5_no_stale_valid", 64'(bus.out_valid), 64'd0);

      // 6: reset mid-operation at count=2
      push_one(32'h0000_0500, 32'h2400_0005);
      push_one(32'h0000_0504, 32'h2400_0006);
      check("t6_count_pre", 64'(bus.count), 64'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_out_valid", 64'(bus.out_valid), 64'd0);
      check("t6_count",     64'(bus.count), 64'd0);
      check("t6_in_ready",  64'(bus.in_ready), 64'd1);
      check("t6_imm16",     64'(bus.out_imm16), 64'd0);
      push_one(32'h0000_0600, 32'h8C00_0010);
      check("t6_new_pc",    64'(bus.out_pc), 64'h600);
      check("t6_new_sext",  64'(bus.out_imm_sext), 64'd1);
      check("t6_new_imm16", 64'(bus.out_imm16), 64'h0010);
      check("t6_new_count", 64'(bus.count), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
